// File: rtl/hbridge_ramp_ctrl.sv
// hbridge_ramp_ctrl: two-channel H-bridge PWM drive with duty slew and dead-timed direction reversal
module hbridge_ramp_ctrl #(
    parameter int DUTY_W       = 6,
    parameter int PRESCALE     = 1,
    parameter int RAMP_PERIODS = 4,
    parameter int DEADTIME     = 16
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [DUTY_W-1:0] speed_cmd,
    input  logic [1:0]        dir_cmd,
    output logic              LeftPWMOut,
    output logic              RightPWMOut,
    output logic [3:0]        TankDir,
    output logic [DUTY_W-1:0] duty_cur,
    output logic              busy
);
    localparam int PW = $clog2(PRESCALE + 1);
    localparam int RW = $clog2(RAMP_PERIODS + 1);
    localparam int DW = $clog2(DEADTIME + 1);

    typedef enum logic [1:0] {IDLE, RUN, RAMP_DN, DEAD} state_t;

    state_t            state, state_nx;
    logic [PW-1:0]     presc_cnt;
    logic [DUTY_W-1:0] pwm_cnt, target, duty_nx;
    logic [RW-1:0]     ramp_cnt;
    logic [DW-1:0]     dead_cnt;
    logic [1:0]        dir_act;
    logic              tick, boundary, drive, step_en, dead_end, load_dir, pwm_q;

    assign tick     = presc_cnt == PW'(PRESCALE - 1);
    assign boundary = tick && (pwm_cnt == '1);
    assign drive    = (state == RUN) || (state == RAMP_DN);
    assign busy     = (state == RAMP_DN) || (state == DEAD);
    assign dead_end = dead_cnt <= DW'(1);
    assign step_en  = boundary && drive && (ramp_cnt == RW'(RAMP_PERIODS - 1));
    assign target   = (state == RUN) ? speed_cmd : '0;
    assign duty_nx  = !step_en            ? duty_cur :
                      (duty_cur < target) ? duty_cur + DUTY_W'(1) :
                      (duty_cur > target) ? duty_cur - DUTY_W'(1) : duty_cur;
    assign load_dir = (state_nx == RUN) && ((state == IDLE) || (state == DEAD));

    assign LeftPWMOut  = pwm_q;
    assign RightPWMOut = pwm_q;
    assign TankDir = !drive              ? 4'b0000 :
                     (dir_act == 2'b00)  ? 4'b0110 :
                     (dir_act == 2'b11)  ? 4'b1001 :
                     (dir_act == 2'b10)  ? 4'b1010 : 4'b0101;

    // enable drop outranks a direction change, but both lead to RAMP_DN anyway
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = enable ? RUN : IDLE;
            RUN:     state_nx = (!enable || dir_cmd != dir_act) ? RAMP_DN : RUN;
            RAMP_DN: state_nx = (duty_cur == '0) ? DEAD : RAMP_DN;
            DEAD:    state_nx = !dead_end ? DEAD : enable ? RUN : IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            presc_cnt <= '0;
            pwm_cnt   <= '0;
            ramp_cnt  <= '0;
            dead_cnt  <= '0;
            dir_act   <= 2'b00;
            duty_cur  <= '0;
            pwm_q     <= 1'b0;
        end else begin
            state     <= state_nx;
            presc_cnt <= tick ? '0 : presc_cnt + PW'(1);
            pwm_cnt   <= tick ? pwm_cnt + DUTY_W'(1) : pwm_cnt;
            ramp_cnt  <= !drive ? '0 :
                         !boundary ? ramp_cnt :
                         (ramp_cnt == RW'(RAMP_PERIODS - 1)) ? '0 : ramp_cnt + RW'(1);
            dead_cnt  <= (state == RAMP_DN && state_nx == DEAD) ? DW'(DEADTIME) :
                         (state == DEAD) ? dead_cnt - DW'(1) : dead_cnt;
            dir_act   <= load_dir ? dir_cmd : dir_act;
            duty_cur  <= duty_nx;
            pwm_q     <= drive && (pwm_cnt < duty_cur);
        end
    end
endmodule

// File: tb/tb_hbridge_ramp_ctrl.sv
// tb_hbridge_ramp_ctrl: directed/randomized scenarios with arithmetic expectations for the ramping H-bridge controller
module tb_hbridge_ramp_ctrl;
    localparam int P  = 16;
    localparam int DT = 4;

    logic       clock = 1'b0, rst_n = 1'b1, enable = 1'b0;
    logic [3:0] speed_cmd = '0;
    logic [1:0] dir_cmd = '0;
    logic       LeftPWMOut, RightPWMOut, busy;
    logic [3:0] TankDir, duty_cur;
    logic [3:0] prev_dir = '0, prev_duty = '0;
    int tests = 0, fails = 0, n = 0, hi = 0, last_hi = 0;
    int s, l, s2, c;

    hbridge_ramp_ctrl #(.DUTY_W(4), .PRESCALE(1), .RAMP_PERIODS(1), .DEADTIME(DT)) dut (
        .clock(clock), .rst_n(rst_n), .enable(enable), .speed_cmd(speed_cmd), .dir_cmd(dir_cmd),
        .LeftPWMOut(LeftPWMOut), .RightPWMOut(RightPWMOut), .TankDir(TankDir),
        .duty_cur(duty_cur), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // one clock; pwm_cnt equals n mod 16, so a period ends on every sample with n % 16 == 0
    task automatic step();
        @(posedge clock);
        #1;
        n++;
        hi += int'(LeftPWMOut);
        chk("pwm_left_eq_right", LeftPWMOut, RightPWMOut);
        chk("dir_direct_change", (prev_dir != 0 && TankDir != 0 && TankDir != prev_dir), 0);
        chk("pwm_while_dir_off", (TankDir == 0 && LeftPWMOut), 0);
        if (n % P != 0) chk("duty_off_boundary", duty_cur, prev_duty);
        else begin
            last_hi = hi;
            hi = 0;
        end
        prev_dir  = TankDir;
        prev_duty = duty_cur;
    endtask

    task automatic to_boundary();
        step();
        while (n % P != 0) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        prev_dir = '0;
        prev_duty = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        rst_n = 1'b1;
        n = 0;
        hi = 0;
    endtask

    task automatic count_zero_dir(output int cnt);
        cnt = 0;
        while (TankDir == 0 && cnt < 20) begin
            cnt++;
            step();
        end
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy && cnt < 40) begin
            cnt++;
            step();
        end
    endtask

    initial begin
        s  = $urandom_range(3, 12);
        s2 = $urandom_range(2, 8);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_dir", TankDir, 4'b0000);
        chk("reset_duty", duty_cur, 0);
        chk("reset_busy", busy, 0);
        chk("reset_pwm", LeftPWMOut, 0);
        do_reset();
        repeat (3) step();
        chk("idle_dir", TankDir, 4'b0000);
        chk("idle_busy", busy, 0);

        // soft start forward to random speed s
        speed_cmd = 4'(s);
        dir_cmd = 2'b00;
        enable = 1'b1;
        step();
        chk("fwd_dir", TankDir, 4'b0110);
        chk("fwd_duty0", duty_cur, 0);
        for (int k = 1; k <= s; k++) begin
            to_boundary();
            chk("ramp_up_duty", duty_cur, k);
            chk("ramp_up_pwm_count", last_hi, k - 1);
        end
        to_boundary();
        chk("ramp_up_saturate", duty_cur, s);
        chk("pwm_count_full", last_hi, s);
        to_boundary();
        chk("pwm_count_steady", last_hi, s);

        // reversal forward -> reverse
        dir_cmd = 2'b11;
        step();
        chk("rev_busy", busy, 1);
        chk("rev_keep_dir", TankDir, 4'b0110);
        for (int d = s - 1; d >= 0; d--) begin
            to_boundary();
            chk("rev_ramp_dn", duty_cur, d);
            chk("rev_busy_dn", busy, 1);
        end
        step();
        chk("rev_dead_dir", TankDir, 4'b0000);
        count_zero_dir(c);
        chk("rev_dead_len", c, DT);
        chk("rev_new_dir", TankDir, 4'b1001);
        chk("rev_busy_clr", busy, 0);
        chk("rev_duty0", duty_cur, 0);
        for (int k = 1; k <= s; k++) begin
            to_boundary();
            chk("rev_ramp_up", duty_cur, k);
        end

        // retarget up to 15 for two steps, then down to random l
        l = $urandom_range(1, s);
        speed_cmd = 4'd15;
        to_boundary();
        chk("retgt_up1", duty_cur, s + 1);
        to_boundary();
        chk("retgt_up2", duty_cur, s + 2);
        speed_cmd = 4'(l);
        for (int d = s + 1; d >= l; d--) begin
            to_boundary();
            chk("retgt_dn", duty_cur, d);
        end
        to_boundary();
        chk("retgt_hold", duty_cur, l);
        chk("retgt_pwm_count", last_hi, l);

        // soft stop
        enable = 1'b0;
        step();
        chk("stop_busy", busy, 1);
        for (int d = l - 1; d >= 0; d--) begin
            to_boundary();
            chk("stop_ramp_dn", duty_cur, d);
        end
        step();
        chk("stop_dead_dir", TankDir, 4'b0000);
        count_busy(c);
        chk("stop_dead_len", c, DT);
        chk("stop_idle_dir", TankDir, 4'b0000);
        to_boundary();
        to_boundary();
        chk("stop_pwm_count", last_hi, 0);
        chk("stop_duty", duty_cur, 0);

        // left spin, request right, then revert mid ramp-down: sequence still completes
        speed_cmd = 4'(s2);
        dir_cmd = 2'b10;
        enable = 1'b1;
        step();
        chk("left_dir", TankDir, 4'b1010);
        for (int k = 1; k <= s2; k++) begin
            to_boundary();
            chk("left_ramp_up", duty_cur, k);
        end
        dir_cmd = 2'b01;
        step();
        chk("abort_busy", busy, 1);
        to_boundary();
        chk("abort_dn1", duty_cur, s2 - 1);
        dir_cmd = 2'b10;
        for (int d = s2 - 2; d >= 0; d--) begin
            to_boundary();
            chk("abort_ramp_dn", duty_cur, d);
        end
        step();
        chk("abort_dead_dir", TankDir, 4'b0000);
        count_zero_dir(c);
        chk("abort_dead_len", c, DT);
        chk("abort_old_dir", TankDir, 4'b1010);
        chk("abort_busy_clr", busy, 0);
        for (int k = 1; k <= s2; k++) begin
            to_boundary();
            chk("abort_ramp_up", duty_cur, k);
        end

        // async reset mid-RUN at duty 9 while PWM is high
        speed_cmd = 4'd9;
        for (int d = s2 + 1; d <= 9; d++) begin
            to_boundary();
            chk("to9_ramp", duty_cur, d);
        end
        to_boundary();
        step();
        chk("pre_rst_pwm", LeftPWMOut, 1);
        chk("pre_rst_duty", duty_cur, 9);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_dir", TankDir, 4'b0000);
        chk("async_rst_lpwm", LeftPWMOut, 0);
        chk("async_rst_rpwm", RightPWMOut, 0);
        chk("async_rst_duty", duty_cur, 0);
        chk("async_rst_busy", busy, 0);
        do_reset();

        // right spin at zero speed, then disable: RAMP_DN with duty 0 goes straight to DEAD
        speed_cmd = '0;
        dir_cmd = 2'b01;
        step();
        chk("right_dir", TankDir, 4'b0101);
        enable = 1'b0;
        step();
        chk("zero_dn_busy", busy, 1);
        chk("zero_dn_dir", TankDir, 4'b0101);
        step();
        chk("zero_dead_dir", TankDir, 4'b0000);
        count_busy(c);
        chk("zero_dead_len", c, DT);
        chk("zero_idle_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
